// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ byte producers share one uart_transmitter.
// It also owns the transmitter's baud select, deferring updates until the line is quiet.
module uart_tx_arbiter #(
  parameter  int NREQ       = 4,
  parameter  int WAIT_LIMIT = 16,
  localparam int GW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              en,
  input  logic [2:0]        cfg_baud,
  input  logic              cfg_baud_wr,
  input  logic              Tx_BUSY,
  output logic [7:0]        Tx_DATA,
  output logic [2:0]        baud_select,
  output logic              Tx_EN,
  output logic              Tx_WR,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [1:0]        dbg_state_o
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [7:0]      tx_data_q;
  logic [2:0]      baud_q;
  logic [2:0]      pend_baud_q;
  logic            pend_q;
  logic            tx_en_q;
  logic            tx_wr_q;
  logic [NREQ-1:0] req_ready_q;
  logic [GW-1:0]   grant_id_q;
  logic            err_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [CW-1:0]   wait_cnt_d;

  logic [7:0]      data_arr [NREQ];
  logic            pick_found;
  logic [GW-1:0]   pick_id;
  logic [NREQ-1:0] pick_oh;
  logic [GW-1:0]   cand;
  int              idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[8*g +: 8];
  end

  // Search starts one past the last grant, so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_id_q;
    pick_oh    = '0;
    cand       = '0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(grant_id_q) + k) % NREQ;
      cand = GW'(idx);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
    pick_oh[pick_id] = pick_found;
  end

  assign wait_cnt_d = (wait_cnt_q == CW'(WAIT_LIMIT)) ? wait_cnt_q : wait_cnt_q + CW'(1);

  // Handshake: req_valid[i] means a byte is offered on req_data lane i and may be
  // withdrawn at any time before acceptance; req_ready[i] pulses for exactly one
  // cycle (the Tx_WR cycle) when that byte has been latched, after which the
  // requester presents its next byte or drops valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      baud_q      <= 3'b111;
      pend_baud_q <= '0;
      pend_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_wr_q     <= 1'b0;
      req_ready_q <= '0;
      grant_id_q  <= GW'(NREQ - 1);
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      tx_en_q     <= en;
      tx_wr_q     <= 1'b0;
      req_ready_q <= '0;
      if (err_clr) err_q <= 1'b0;
      if (cfg_baud_wr && state_q != IDLE) begin
        pend_q      <= 1'b1;
        pend_baud_q <= cfg_baud;
      end
      case (state_q)
        IDLE: begin
          // A baud change takes priority over a grant and waits for a quiet line.
          if (cfg_baud_wr || pend_q) begin
            if (!Tx_BUSY) begin
              baud_q <= cfg_baud_wr ? cfg_baud : pend_baud_q;
              pend_q <= 1'b0;
            end else begin
              pend_q <= 1'b1;
              if (cfg_baud_wr) pend_baud_q <= cfg_baud;
            end
          end else if (en && pick_found) begin
            tx_data_q   <= data_arr[pick_id];
            grant_id_q  <= pick_id;
            req_ready_q <= pick_oh;
            tx_wr_q     <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (Tx_BUSY) begin
            state_q <= WAIT_DONE;
          end else if (wait_cnt_q >= CW'(WAIT_LIMIT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        WAIT_DONE: begin
          if (!Tx_BUSY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Tx_DATA     = tx_data_q;
  assign baud_select = baud_q;
  assign Tx_EN       = tx_en_q;
  assign Tx_WR       = tx_wr_q;
  assign req_ready   = req_ready_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter: requester queues feed the DUT,
// a round-robin reference predicts the grant order, and a monitor scores every Tx_WR.
module tb_uart_tx_arbiter;

  localparam int NREQ       = 4;
  localparam int WAIT_LIMIT = 16;
  localparam int GW         = $clog2(NREQ);
  localparam int W          = GW + 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              en;
  logic [2:0]        cfg_baud;
  logic              cfg_baud_wr;
  logic              Tx_BUSY;
  logic [7:0]        Tx_DATA;
  logic [2:0]        baud_select;
  logic              Tx_EN;
  logic              Tx_WR;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              err_timeout;
  logic              err_clr;
  logic [1:0]        dbg_state;

  uart_tx_arbiter #(.NREQ(NREQ), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .en(en), .cfg_baud(cfg_baud), .cfg_baud_wr(cfg_baud_wr),
    .Tx_BUSY(Tx_BUSY), .Tx_DATA(Tx_DATA), .baud_select(baud_select), .Tx_EN(Tx_EN),
    .Tx_WR(Tx_WR), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout),
    .err_clr(err_clr), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests    = 0;
  int n_fail     = 0;
  int wr_count   = 0;
  int model_last = NREQ - 1;
  logic [W-1:0] exp_q[$];

  logic [7:0] src_mem  [NREQ][16];
  int         src_head [NREQ];
  int         src_tail [NREQ];

  bit tx_on   = 1'b1;
  bit tx_rand = 1'b0;
  int tx_rise = 2;
  int tx_len  = 20;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bounded wait expired at t=%0t", name, $time);
  endtask

  function automatic int rr_next(input int last, input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction

  // Reference: all pending bytes are served in round-robin turns from last+1.
  task automatic predict();
    int p [NREQ];
    logic [NREQ-1:0] m;
    int id;
    for (int i = 0; i < NREQ; i++) p[i] = src_head[i];
    forever begin
      m = '0;
      for (int i = 0; i < NREQ; i++) m[i] = (p[i] < src_tail[i]);
      if (m == '0) break;
      id = rr_next(model_last, m);
      exp_q.push_back({GW'(id), src_mem[id][p[id]]});
      p[id]++;
      model_last = id;
    end
  endtask

  // ---------------- requester driver ----------------
  initial begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i] && src_head[i] < src_tail[i]) src_head[i]++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]      = (src_head[i] < src_tail[i]);
        req_data[8*i +: 8] = req_valid[i] ? src_mem[i][src_head[i]] : 8'h00;
      end
    end
  end

  // ---------------- transmitter model ----------------
  initial begin
    int r;
    int l;
    Tx_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (Tx_WR && tx_on) begin
        r = tx_rand ? int'($urandom_range(1, 5)) : tx_rise;
        l = tx_rand ? int'($urandom_range(1, 8)) : tx_len;
        repeat (r) @(posedge clk);
        #1 Tx_BUSY = 1'b1;
        repeat (l) @(posedge clk);
        #1 Tx_BUSY = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0]    e;
    logic [NREQ-1:0] oh;
    logic            prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (Tx_WR) begin
        wr_count++;
        chk("tx_wr_single_cycle", prev_wr, 0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_grant: actual id=%0d data=%0h required=none at t=%0t",
                   grant_id, Tx_DATA, $time);
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e[W-1:8]] = 1'b1;
          chk("grant_id", grant_id, e[W-1:8]);
          chk("tx_data", Tx_DATA, e[7:0]);
          chk("req_ready_onehot", req_ready, oh);
        end
      end else begin
        chk("req_ready_idle", req_ready, 0);
      end
      prev_wr = Tx_WR;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    @(negedge clk);
    #2;
    for (int i = 0; i < NREQ; i++)
      if (src_head[i] == src_tail[i]) begin
        src_head[i] = 0;
        src_tail[i] = 0;
      end
  endtask

  task automatic load(input int id, input logic [7:0] b);
    src_mem[id][src_tail[id]] = b;
    src_tail[id]++;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_data"}, Tx_DATA, 0);
    chk({tag, "_tx_wr"}, Tx_WR, 0);
    chk({tag, "_tx_en"}, Tx_EN, 0);
    chk({tag, "_baud"}, baud_select, 3'b111);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_grant_id"}, grant_id, NREQ - 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && !Tx_BUSY && !Tx_WR && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic wait_wr(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (Tx_WR) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic wait_in_transfer(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy && Tx_BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic wait_busy_low(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!Tx_BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    bit bad_baud;
    int wc;
    reset = 1'b0; en = 1'b0; cfg_baud = 3'b000; cfg_baud_wr = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    @(negedge clk);
    reset = 1'b1;

    // Single request, transmitter busy 2 cycles after Tx_WR for 20 cycles.
    next_drive(); en = 1'b1;
    tx_rand = 1'b0; tx_rise = 2; tx_len = 20;
    begin_load(); load(0, 8'hAA); predict();
    wait_wr("t1_wr", ok);
    wait_in_transfer("t1_busy_rise", ok);
    wait_busy_low("t1_busy_fall", ok);
    chk("t1_busy_before_edge", busy, 1);
    @(negedge clk);
    chk("t1_busy_after_fall", busy, 0);
    chk("t1_data_hold", Tx_DATA, 8'hAA);
    wait_idle("t1_idle", 100);

    // Fresh reset, all four requesters: order 0,1,2,3,0.
    next_drive(); reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst1");
    reset = 1'b1;
    model_last = NREQ - 1;
    tx_rise = 1; tx_len = 3;
    begin_load();
    load(0, 8'h10); load(0, 8'h10); load(1, 8'h21); load(2, 8'h32); load(3, 8'h43);
    predict();
    wait_idle("t2_idle", 300);

    // Missing Tx_BUSY: timeout after exactly WAIT_LIMIT wait cycles.
    tx_on = 1'b0;
    begin_load(); load(1, 8'h5C); predict();
    wait_wr("t3_wr", ok);
    if (ok) begin
      repeat (WAIT_LIMIT) @(negedge clk);
      chk("t3_still_waiting", busy, 1);
      chk("t3_err_not_yet", err_timeout, 0);
      @(negedge clk);
      chk("t3_back_idle", busy, 0);
      chk("t3_err_set", err_timeout, 1);
      repeat (3) @(negedge clk);
      chk("t3_err_sticky", err_timeout, 1);
      next_drive(); err_clr = 1'b1;
      next_drive(); err_clr = 1'b0;
      @(negedge clk);
      chk("t3_err_cleared", err_timeout, 0);
    end
    // Clear held through a second timeout: set wins on the timeout edge.
    next_drive(); err_clr = 1'b1;
    begin_load(); load(2, 8'h6D); predict();
    wait_wr("t3b_wr", ok);
    if (ok) begin
      repeat (WAIT_LIMIT) @(negedge clk);
      chk("t3b_err_not_yet", err_timeout, 0);
      @(negedge clk);
      chk("t3b_set_wins", err_timeout, 1);
      @(negedge clk);
      chk("t3b_clear_after", err_timeout, 0);
    end
    next_drive(); err_clr = 1'b0;
    tx_on = 1'b1;

    // Baud writes during a transfer are deferred; latest one wins.
    tx_rise = 2; tx_len = 12;
    begin_load(); load(3, 8'h7E); load(0, 8'h81); predict();
    wait_in_transfer("t4_transfer", ok);
    next_drive(); cfg_baud = 3'b100; cfg_baud_wr = 1'b1;
    next_drive(); cfg_baud_wr = 1'b0;
    next_drive(); cfg_baud = 3'b010; cfg_baud_wr = 1'b1;
    next_drive(); cfg_baud_wr = 1'b0;
    bad_baud = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!Tx_BUSY) begin
        ok = 1'b1;
        break;
      end
      if (baud_select != 3'b111) bad_baud = 1'b1;
    end
    if (!ok) fail_now("t4_busy_fall");
    chk("t4_baud_held_while_busy", bad_baud, 0);
    chk("t4_baud_at_fall", baud_select, 3'b111);
    @(negedge clk);
    chk("t4_first_idle_busy", busy, 0);
    chk("t4_first_idle_baud", baud_select, 3'b111);
    chk("t4_first_idle_no_wr", Tx_WR, 0);
    @(negedge clk);
    chk("t4_baud_applied", baud_select, 3'b010);
    chk("t4_grant_delayed", Tx_WR, 0);
    @(negedge clk);
    chk("t4_grant_after_baud", Tx_WR, 1);
    wait_idle("t4_idle", 100);
    next_drive(); cfg_baud = 3'b101; cfg_baud_wr = 1'b1;
    next_drive(); cfg_baud_wr = 1'b0;
    @(negedge clk);
    chk("t4_idle_baud_write", baud_select, 3'b101);

    // Asynchronous reset in WAIT_DONE, with a baud update pending.
    tx_rise = 2; tx_len = 20;
    begin_load(); load(1, 8'h92); predict();
    wait_in_transfer("t5_transfer", ok);
    next_drive(); cfg_baud = 3'b011; cfg_baud_wr = 1'b1;
    next_drive(); cfg_baud_wr = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_async");
    wait_busy_low("t5_busy_fall", ok);
    @(negedge clk);
    reset = 1'b1;
    model_last = NREQ - 1;
    begin_load(); load(2, 8'hA3); predict();
    wait_idle("t5_idle", 100);
    chk("t5_pending_cleared", baud_select, 3'b111);

    // en=0 blocks grants; in-flight transfer still completes.
    next_drive(); en = 1'b0;
    @(negedge clk);
    wc = wr_count;
    begin_load(); load(0, 8'hB4); load(1, 8'hC5); predict();
    repeat (10) @(negedge clk);
    chk("t6_no_wr_while_disabled", wr_count, wc);
    chk("t6_tx_en_low", Tx_EN, 0);
    next_drive(); en = 1'b1;
    @(negedge clk);
    chk("t6_tx_en_lag", Tx_EN, 0);
    @(negedge clk);
    chk("t6_tx_en_high", Tx_EN, 1);
    chk("t6_grant_on_enable", Tx_WR, 1);
    next_drive(); en = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && !Tx_BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("t6_transfer_complete");
    repeat (6) @(negedge clk);
    chk("t6_single_grant_while_off", wr_count, wc + 1);
    next_drive(); en = 1'b1;
    wait_idle("t6_idle", 100);
    chk("t6_second_grant", wr_count, wc + 2);

    // Randomised rounds against the round-robin reference.
    tx_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      begin_load();
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int j = 0; j < n; j++) load(i, 8'($urandom_range(0, 255)));
      end
      predict();
      wait_idle("rand_round_idle", 600);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one uart_transmitter.
REQ-002 The block SHALL have parameter WAIT_LIMIT, default 16, giving the maximum cycles to wait for Tx_BUSY to rise after Tx_WR.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: requester i has a byte pending.
REQ-006 The block SHALL have port req_data, input, 8*NREQ bits: byte of requester i on bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, NREQ bits: one-hot, one-cycle pulse when requester i's byte is accepted.
REQ-008 The block SHALL have port en, input, 1 bit: arbitration enable, driven onto Tx_EN.
REQ-009 The block SHALL have port cfg_baud, input, 3 bits: new baud_select value.
REQ-010 The block SHALL have port cfg_baud_wr, input, 1 bit: write strobe for cfg_baud.
REQ-011 The block SHALL have port Tx_BUSY, input, 1 bit: busy output of the transmitter.
REQ-012 The block SHALL have port Tx_DATA, output, 8 bits: byte to the transmitter.
REQ-013 The block SHALL have port baud_select, output, 3 bits: baud rate select to the transmitter.
REQ-014 The block SHALL have port Tx_EN, output, 1 bit: transmitter enable.
REQ-015 The block SHALL have port Tx_WR, output, 1 bit: one-cycle write strobe to the transmitter.
REQ-016 The block SHALL have port grant_id, output, clog2(NREQ) bits: index of the last granted requester.
REQ-017 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 The block SHALL have port err_timeout, output, 1 bit: sticky error flag for a missing Tx_BUSY.
REQ-019 The block SHALL have port err_clr, input, 1 bit: clears err_timeout.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-021 In IDLE with en=1, any req_valid bit set and no pending baud update, the block SHALL, on the next edge:
- grant requester i, chosen round-robin starting at (last grant + 1) mod NREQ;
- register Tx_DATA from req_data[i] and grant_id from i;
- move to ISSUE.
REQ-022 req_ready[i] SHALL be high only during the ISSUE cycle of grant i, with all other bits 0.
REQ-023 Tx_WR SHALL be 1 only in ISSUE, so exactly one cycle per grant, and the FSM SHALL then move to WAIT_ACK.
REQ-024 Latency from req_valid sampled in IDLE to Tx_WR high SHALL be exactly 1 cycle.
REQ-025 In WAIT_ACK, Tx_BUSY=1 SHALL move the FSM to WAIT_DONE.
REQ-026 In WAIT_ACK, if Tx_BUSY is still 0 after WAIT_LIMIT cycles, the block SHALL set err_timeout and return to IDLE.
- The wait counter SHALL saturate and SHALL not wrap.
- The timed-out grant SHALL still count as the last grant.
REQ-027 In WAIT_DONE, Tx_BUSY=0 SHALL return the FSM to IDLE.
REQ-028 Tx_DATA SHALL hold its value from grant until the next grant.
REQ-029 Tx_EN SHALL equal en registered by one cycle.
REQ-030 While en=0, no new grant SHALL be issued, but a transfer already in progress SHALL complete.
REQ-031 cfg_baud_wr in IDLE SHALL update baud_select on the next edge, and that edge SHALL issue no grant.
REQ-032 cfg_baud_wr outside IDLE SHALL store cfg_baud as pending, with the latest write winning.
- The pending value SHALL be applied on the first IDLE cycle.
- That IDLE cycle SHALL issue no grant.
- baud_select SHALL never change while Tx_BUSY or busy is high.
REQ-033 If err_clr and a timeout event occur in the same cycle, the set SHALL win.
REQ-034 A requester dropping req_valid before grant SHALL simply not be considered, and data latched at grant SHALL be unaffected.

Reset
REQ-035 Asserting reset (low) SHALL immediately force the following, including mid-transfer:
- state IDLE;
- Tx_DATA=0, Tx_WR=0, Tx_EN=0;
- baud_select=3'b111;
- req_ready=0, grant_id=NREQ-1 (so requester 0 is first), busy=0, err_timeout=0;
- pending baud cleared and wait counter 0.

Verification
REQ-036 A bench SHALL cover: en=1, req_valid=0001, req_data[7:0]=8'hAA, Tx_BUSY model rising 2 cycles after Tx_WR and lasting 20 cycles -> Tx_WR one cycle, Tx_DATA=8'hAA, req_ready=0001 in the same cycle, busy low after Tx_BUSY falls.
REQ-037 A bench SHALL cover: req_valid=1111 held, data 8'h10/8'h21/8'h32/8'h43 -> grants in order 0,1,2,3,0 and Tx_DATA sequence 10,21,32,43,10.
REQ-038 A bench SHALL cover: Tx_BUSY tied 0 and one request -> err_timeout=1 after 16 WAIT_ACK cycles, FSM back in IDLE, err_clr clears the flag.
REQ-039 A bench SHALL cover: cfg_baud_wr with 3'b010 during WAIT_DONE -> baud_select stays 3'b111 until Tx_BUSY falls, becomes 3'b010 in IDLE, and the next grant is delayed one cycle.
REQ-040 A bench SHALL cover: reset low during WAIT_DONE -> all outputs at reset values asynchronously; after release with req_valid=0100, requester 2 is granted.
REQ-041 A bench SHALL cover: en=0 with req_valid=0011 -> no Tx_WR and Tx_EN=0; after en returns to 1, requester 0 is granted first.
